// File: rtl/chan_mux_rr_if.sv
// Handshake bundle for chan_mux_rr: N input lanes in, one tagged lane out.
// master drives the lanes and out_ready; slave is the mux itself.
interface chan_mux_rr_if #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
);
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_chan,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_chan,
    output out_valid
  );
endinterface

// File: rtl/chan_mux_rr.sv
// N-channel registered mux: manual select or round-robin scan,
// one tagged word per clock onto a back-pressured output register.
module chan_mux_rr #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_rr_if.slave  bus
);
  localparam int SELW = $clog2(N);

  logic [W-1:0]    lane [N];
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nxt;
  logic [SELW-1:0] rr_idx;
  logic            rr_hit;
  logic            man_ok;
  logic [SELW-1:0] gnt;
  logic            gnt_vld;
  logic            load;
  logic            take;
  logic [W-1:0]    q_data;
  logic [SELW-1:0] q_chan;
  logic            q_valid;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane[i] = bus.in_data[i*W +: W];
  end

  // Scan from the top offset down so the nearest requester after ptr wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (bus.in_valid[SELW'(c)]) begin
        rr_hit = 1'b1;
        rr_idx = SELW'(c);
      end
    end
  end

  assign man_ok = (int'(bus.sel) < N) &&
                  bus.in_valid[bus.sel];

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    unique case (1'b1)
      bus.mode: begin
        gnt_vld = rr_hit;
        gnt     = rr_idx;
      end
      default: begin
        gnt_vld = man_ok;
        gnt     = bus.sel;
      end
    endcase
  end

  assign load = !q_valid || bus.out_ready;
  assign take = rst_n && gnt_vld && load;

  always_comb begin
    bus.in_ready = '0;
    if (take) bus.in_ready[gnt] = 1'b1;
  end

  assign ptr_nxt = (gnt == SELW'(N - 1)) ?
                   '0 : gnt + SELW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_chan  <= '0;
    end else if (load) begin
      q_valid <= gnt_vld;
      if (gnt_vld) begin
        q_data <= lane[gnt];
        q_chan <= gnt;
      end
    end
  end

  // Manual mode leaves ptr alone so the scan resumes where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take && bus.mode) begin
      ptr <= ptr_nxt;
    end
  end

  assign bus.out_data  = q_data;
  assign bus.out_chan  = q_chan;
  assign bus.out_valid = q_valid;
endmodule
